// File: rtl/phy_pkg.sv
// Shared constants for the phy_tx / phy_rx pair: comma symbol, byte width,
// and the receive-side alignment state encoding.
package phy_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COM_SYMBOL_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receive deserializer: slides over the bit stream until a
// comma is seen, confirms COM_NEEDED aligned commas, then emits bytes on dclk.
module serial_paralelo
    import phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYMBOL = COM_SYMBOL_DEFAULT,
    parameter int unsigned       COM_NEEDED = 4
) (
    input  logic              dclk,
    input  logic              default_values,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active,
    output logic              byte_strobe
);

    localparam logic [3:0] COM_TARGET = 4'(COM_NEEDED);

    state_t            state, state_nx;
    logic [BYTE_W-1:0] sr;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic [3:0]        com_cnt, com_cnt_nx;
    logic [BYTE_W-1:0] data_nx;
    logic              valid_nx;
    logic              strobe_nx;

    logic [BYTE_W-1:0] nb;
    logic              is_com;
    logic              byte_done;

    // Candidate byte includes the bit being sampled on this edge.
    assign nb        = {sr[BYTE_W-2:0], data_in};
    assign is_com    = (nb == COM_SYMBOL);
    assign byte_done = (bit_cnt == 3'd7);
    assign active    = (state == ACTIVE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 3'd1;
        com_cnt_nx = com_cnt;
        data_nx    = data_out;
        valid_nx   = valid_out;
        strobe_nx  = 1'b0;

        case (state)
            SEARCH: begin
                bit_cnt_nx = '0;
                if (is_com) begin
                    com_cnt_nx = 4'd1;
                    state_nx   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (byte_done) begin
                    strobe_nx = 1'b1;
                    if (is_com) begin
                        com_cnt_nx = com_cnt + 4'd1;
                        if (com_cnt + 4'd1 == COM_TARGET) state_nx = ACTIVE;
                    end else begin
                        // A broken run restarts the sliding search on the next bit.
                        com_cnt_nx = '0;
                        state_nx   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (byte_done) begin
                    strobe_nx = 1'b1;
                    if (is_com) begin
                        valid_nx = 1'b0;
                    end else begin
                        data_nx  = nb;
                        valid_nx = 1'b1;
                    end
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge dclk or posedge default_values) begin
        if (default_values) begin
            state       <= SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            com_cnt     <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state       <= state_nx;
            sr          <= nb;
            bit_cnt     <= bit_cnt_nx;
            com_cnt     <= com_cnt_nx;
            data_out    <= data_nx;
            valid_out   <= valid_nx;
            byte_strobe <= strobe_nx;
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: byte-level reference model of lock
// acquisition and payload delivery, compared against the DUT on every dclk edge.
module tb_serial_paralelo;
    import phy_pkg::*;

    localparam int         N   = 4;
    localparam logic [7:0] COM = 8'hBC;

    localparam int HUNT   = 0;
    localparam int COUNT  = 1;
    localparam int LOCKED = 2;

    logic       dclk = 1'b0;
    logic       default_values = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] stream[$];

    serial_paralelo #(.COM_SYMBOL(COM), .COM_NEEDED(N)) dut (
        .dclk           (dclk),
        .default_values (default_values),
        .data_in        (data_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .active         (active),
        .byte_strobe    (byte_strobe)
    );

    always #5 dclk = ~dclk;

    task automatic check_outputs(input string name, input int edge_idx, input logic [7:0] e_data,
                                 input logic e_valid, input logic e_active, input logic e_strobe);
        n_cmp++;
        if (data_out !== e_data) begin
            n_bad++;
            $display("FAIL %s data_out edge %0d: got %h expected %h", name, edge_idx, data_out, e_data);
        end
        n_cmp++;
        if (valid_out !== e_valid) begin
            n_bad++;
            $display("FAIL %s valid_out edge %0d: got %b expected %b", name, edge_idx, valid_out, e_valid);
        end
        n_cmp++;
        if (active !== e_active) begin
            n_bad++;
            $display("FAIL %s active edge %0d: got %b expected %b", name, edge_idx, active, e_active);
        end
        n_cmp++;
        if (byte_strobe !== e_strobe) begin
            n_bad++;
            $display("FAIL %s byte_strobe edge %0d: got %b expected %b", name, edge_idx, byte_strobe, e_strobe);
        end
    endtask

    task automatic apply_reset();
        default_values = 1'b1;
        data_in = 1'b0;
        @(posedge dclk);
        @(negedge dclk);
        default_values = 1'b0;
    endtask

    // Sends junk random bits then the bytes in `stream`, MSB first, for at most
    // nbits edges (0 = whole stream). Expected outputs come from a per-byte model.
    task automatic run_stream(input string name, input int junk, input int nbits);
        logic       bits[$];
        logic [7:0] e_data;
        logic       e_valid, e_active, e_strobe;
        logic [7:0] b;
        int         mode;
        int         cnt;
        int         total;
        e_data = 8'h00;
        e_valid = 1'b0;
        e_active = 1'b0;
        mode = HUNT;
        cnt = 0;
        for (int i = 0; i < junk; i++) bits.push_back(1'($urandom_range(0, 1)));
        foreach (stream[k]) for (int j = 7; j >= 0; j--) bits.push_back(stream[k][j]);
        total = (nbits == 0 || nbits > bits.size()) ? bits.size() : nbits;
        for (int e = 0; e < total; e++) begin
            data_in = bits[e];
            @(posedge dclk);
            #1;
            e_strobe = 1'b0;
            if (e >= junk && (e - junk) % 8 == 7) begin
                b = stream[(e - junk) / 8];
                case (mode)
                    HUNT: begin
                        if (b == COM) begin
                            cnt = 1;
                            mode = (cnt == N) ? LOCKED : COUNT;
                            e_active = (cnt == N);
                        end
                    end
                    COUNT: begin
                        e_strobe = 1'b1;
                        if (b == COM) begin
                            cnt++;
                            if (cnt == N) begin
                                mode = LOCKED;
                                e_active = 1'b1;
                            end
                        end else begin
                            cnt = 0;
                            mode = HUNT;
                        end
                    end
                    default: begin
                        e_strobe = 1'b1;
                        if (b == COM) e_valid = 1'b0;
                        else begin
                            e_data = b;
                            e_valid = 1'b1;
                        end
                    end
                endcase
            end
            check_outputs(name, e, e_data, e_valid, e_active, e_strobe);
        end
    endtask

    // Asserts reset between edges and expects every output cleared before any edge.
    task automatic async_reset_check(input string name);
        #2;
        default_values = 1'b1;
        #1;
        check_outputs({name, "_async"}, -1, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge dclk);
        #1;
        check_outputs({name, "_held"}, -1, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge dclk);
        default_values = 1'b0;
        @(posedge dclk);
        #1;
        check_outputs({name, "_release"}, -1, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] rand_payload();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255)); while (v == COM);
        return v;
    endfunction

    task automatic load_basic();
        stream.delete();
        repeat (4) stream.push_back(COM);
        stream.push_back(8'hFF);
        stream.push_back(8'hDD);
        stream.push_back(8'hEE);
        stream.push_back(8'hCC);
        repeat (2) stream.push_back(COM);
    endtask

    task automatic test_reset();
        apply_reset();
        check_outputs("reset_initial", -1, 8'h00, 1'b0, 1'b0, 1'b0);
        load_basic();
        run_stream("reset_prelock", 0, 0);
        async_reset_check("reset_mid_sim");
    endtask

    task automatic test_lock_and_data();
        apply_reset();
        load_basic();
        run_stream("lock_data", 0, 0);
    endtask

    task automatic test_misaligned();
        apply_reset();
        load_basic();
        run_stream("misaligned3", 3, 0);
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            stream.delete();
            repeat (4) stream.push_back(COM);
            repeat ($urandom_range(3, 6)) stream.push_back(rand_payload());
            stream.push_back(COM);
            stream.push_back(rand_payload());
            stream.push_back(COM);
            run_stream("misaligned_rand", $urandom_range(0, 7), 0);
        end
    endtask

    task automatic test_broken_lock();
        apply_reset();
        stream.delete();
        repeat (3) stream.push_back(COM);
        stream.push_back(8'h55);
        repeat (4) stream.push_back(COM);
        stream.push_back(8'hA5);
        stream.push_back(COM);
        run_stream("broken_lock", 0, 0);
        apply_reset();
        stream.delete();
        repeat ($urandom_range(1, 3)) stream.push_back(COM);
        stream.push_back(rand_payload());
        repeat (4) stream.push_back(COM);
        stream.push_back(rand_payload());
        run_stream("broken_lock_rand", $urandom_range(0, 7), 0);
    endtask

    task automatic test_idle_in_active();
        apply_reset();
        stream.delete();
        repeat (4) stream.push_back(COM);
        stream.push_back(8'h12);
        stream.push_back(COM);
        stream.push_back(8'h34);
        stream.push_back(COM);
        run_stream("idle_active", 0, 0);
    endtask

    task automatic test_reset_mid_active();
        apply_reset();
        stream.delete();
        repeat (4) stream.push_back(COM);
        stream.push_back(8'h12);
        stream.push_back(8'h9A);
        run_stream("mid_active", 0, 6 * 8 - 4);
        async_reset_check("mid_active_reset");
        apply_reset();
        stream.delete();
        repeat (4) stream.push_back(COM);
        stream.push_back(8'h56);
        stream.push_back(COM);
        run_stream("relock", 0, 0);
    endtask

    initial begin
        test_reset();
        test_lock_and_data();
        test_misaligned();
        test_broken_lock();
        test_idle_in_active();
        test_reset_mid_active();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive-side deserializer for phy_rx, the counterpart of the phy_tx parallel-to-serial block.
- Samples one serial bit per dclk, MSB first.
- Locks byte alignment on the COM symbol, then delivers 8-bit bytes with a valid flag.
- Runs entirely on the bit clock. Byte-rate consumers use byte_strobe as their enable.

Parameters:
- COM_SYMBOL, 8'hBC: comma byte used for alignment; also the idle byte sent by the transmitter when valid=0.
- COM_NEEDED, 4: consecutive aligned COMs required to declare lock (legal range 1..15).

Ports:
- dclk  input  1  bit clock; all state changes on its rising edge.
- default_values  input  1  asynchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received non-COM byte; held stable between byte boundaries.
- valid_out  output  1  high while data_out holds a payload byte from the current byte period.
- active  output  1  high once lock is achieved.
- byte_strobe  output  1  one-dclk pulse on the edge a byte completes (ALIGN and ACTIVE only).

Behaviour:
- Reset (async, while default_values=1): all outputs and internal state cleared.
  - data_out=8'h00, valid_out=0, active=0, byte_strobe=0.
  - Internal: shift register=0, bit_cnt=0, com_cnt=0, state=SEARCH.
  - Reset release takes effect at the next dclk edge.
- Shift register:
  - Every edge outside reset: sr <= {sr[6:0], data_in}.
  - Combinational candidate byte: nb = {sr[6:0], data_in}.
- States: SEARCH, ALIGN, ACTIVE.
- SEARCH:
  - Each edge, compare nb to COM_SYMBOL (bit-by-bit sliding search).
  - On match: bit_cnt <= 0, com_cnt <= 1.
  - If COM_NEEDED=1, go to ACTIVE; otherwise go to ALIGN.
  - No byte_strobe is issued in SEARCH.
- ALIGN:
  - bit_cnt increments mod 8 each edge.
  - When bit_cnt==7, a byte is complete: pulse byte_strobe.
  - If nb==COM_SYMBOL: com_cnt++. When com_cnt+1==COM_NEEDED, go to ACTIVE and set active=1 on that same edge.
  - If nb!=COM_SYMBOL: com_cnt <= 0 and return to SEARCH.
    - The search restarts with the next bit; the current nb is not re-checked.
- ACTIVE:
  - bit_cnt increments mod 8.
  - On bit_cnt==7: byte_strobe=1.
    - If nb!=COM_SYMBOL: data_out <= nb, valid_out <= 1.
    - If nb==COM_SYMBOL: valid_out <= 0 and data_out keeps its previous value.
  - valid_out and data_out are held for the full 8-cycle byte period.
  - Latency: data_out and valid_out update on the same edge that samples the byte's LSB.
  - ACTIVE is left only by reset; there is no in-band loss-of-lock detection.
- Simultaneous events: reset dominates everything.
- Width rules:
  - bit_cnt is 3 bits and wraps 7->0 naturally.
  - com_cnt is 4 bits and saturates at COM_NEEDED.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYMBOL default (8'hBC).
  - BYTE_W=8.
  - State encoding localparams: SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
- The phy_tx serializer uses the same COM constant.
- No sub-module is required. An optional comma_detect comparator may be split out, but it is kept inline by default.

Test Plan:
1. Reset: assert default_values mid-simulation -> all outputs immediately 0, independent of dclk; after release, state is SEARCH and active=0.
2. Lock and data:
   - Stimulus: 4x 8'hBC, then FF, DD, EE, CC, then 8'hBC idle.
   - active rises on the LSB edge of the 4th COM.
   - data_out is FF, DD, EE, CC in consecutive byte periods, each with valid_out=1 and one byte_strobe.
   - valid_out=0 during the idle COM period.
3. Misaligned start: 3 random junk bits, then the stream from test 2 -> identical outputs, with alignment found at bit offset 3.
4. Broken lock attempt:
   - Stimulus: 3x BC, then 8'h55, then 4x BC, then 8'hA5.
   - active stays 0 through the 55 byte and the search restarts.
   - active rises after the second run of 4 COMs.
   - data_out=A5 with valid_out=1.
5. Idle in ACTIVE:
   - Stimulus: lock, send 8'h12, then BC, then 8'h34.
   - valid_out is 1, 0, 1 over the three periods.
   - data_out is 12, 12, 34.
6. Reset mid-ACTIVE:
   - Assert reset during bit 4 of a payload byte.
   - Outputs clear at once.
   - After release, 4 fresh COMs are needed before active returns to 1.
